// File: rtl/iz_param_sender.sv
// Serial framer for Izhikevich a/b/c/d codes: SYNC, 32 MSB-first bits, then a GAP; frame period 34+GAP cycles.
// No backpressure: start is only taken in IDLE, and enable=0 freezes every register, including the outputs.
module iz_param_sender #(
   parameter int GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       start,
   input  logic [7:0] code_a,
   input  logic [7:0] code_b,
   input  logic [7:0] code_c,
   input  logic [7:0] code_d,
   output logic       serial_data_out,
   output logic       load_enable_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] frames_sent,
   output logic [1:0] send_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } state_t;

   // A zero gap would never release the loader, so it is promoted to one cycle.
   localparam int         GAP_INT = (GAP_CYCLES < 1) ? 1 : ((GAP_CYCLES > 15) ? 15 : GAP_CYCLES);
   localparam logic [3:0] GAP_LD  = GAP_INT[3:0];

   state_t      state, state_nxt;
   logic [31:0] frame_reg, frame_nxt;
   logic [4:0]  bit_cnt, bit_nxt;
   logic [3:0]  gap_cnt, gap_nxt;
   logic        sdo_nxt, le_nxt, busy_nxt, done_nxt;
   logic [7:0]  frames_nxt;

   // Outputs are registered, so each branch computes what the link shows in the next cycle.
   // The first data bit is therefore emitted on the SYNC->SHIFT edge.
   always_comb begin
      state_nxt  = state;
      frame_nxt  = frame_reg;
      bit_nxt    = bit_cnt;
      gap_nxt    = gap_cnt;
      sdo_nxt    = 1'b0;
      le_nxt     = 1'b0;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      frames_nxt = frames_sent;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SYNC;
               frame_nxt = {code_a, code_b, code_c, code_d};
               bit_nxt   = 5'd0;
               le_nxt    = 1'b1;
               busy_nxt  = 1'b1;
            end
         end
         SYNC: begin
            state_nxt = SHIFT;
            le_nxt    = 1'b1;
            busy_nxt  = 1'b1;
            sdo_nxt   = frame_reg[31];
            frame_nxt = {frame_reg[30:0], 1'b0};
         end
         SHIFT: begin
            busy_nxt = 1'b1;
            if (bit_cnt == 5'd31) begin
               state_nxt = GAP;
               gap_nxt   = GAP_LD;
            end else begin
               le_nxt    = 1'b1;
               sdo_nxt   = frame_reg[31];
               frame_nxt = {frame_reg[30:0], 1'b0};
               bit_nxt   = bit_cnt + 5'd1;
            end
         end
         GAP: begin
            if (gap_cnt <= 4'd1) begin
               state_nxt  = IDLE;
               gap_nxt    = 4'd0;
               done_nxt   = 1'b1;
               frames_nxt = frames_sent + 8'd1;
            end else begin
               busy_nxt = 1'b1;
               gap_nxt  = gap_cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         frame_reg       <= 32'd0;
         bit_cnt         <= 5'd0;
         gap_cnt         <= 4'd0;
         serial_data_out <= 1'b0;
         load_enable_out <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         frames_sent     <= 8'd0;
      end else if (enable) begin
         state           <= state_nxt;
         frame_reg       <= frame_nxt;
         bit_cnt         <= bit_nxt;
         gap_cnt         <= gap_nxt;
         serial_data_out <= sdo_nxt;
         load_enable_out <= le_nxt;
         busy            <= busy_nxt;
         done            <= done_nxt;
         frames_sent     <= frames_nxt;
      end
   end

   assign send_state = state;

endmodule

// File: tb/tb_iz_param_sender.sv
// Bench for iz_param_sender: two instances (gap 2 and gap 0) share stimulus and are checked
// every cycle against a frame-offset model, plus directed literal checks.
module tb_iz_param_sender;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       enable = 1'b0;
   logic       start = 1'b0;
   logic [7:0] code_a = 8'd0, code_b = 8'd0, code_c = 8'd0, code_d = 8'd0;

   logic       sdo0, le0, busy0, done0, sdo1, le1, busy1, done1;
   logic [7:0] fs0, fs1;
   logic [1:0] st0, st1;

   iz_param_sender #(.GAP_CYCLES(2)) u0 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .start(start),
      .code_a(code_a), .code_b(code_b), .code_c(code_c), .code_d(code_d),
      .serial_data_out(sdo0), .load_enable_out(le0), .busy(busy0), .done(done0),
      .frames_sent(fs0), .send_state(st0)
   );

   iz_param_sender #(.GAP_CYCLES(0)) u1 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .start(start),
      .code_a(code_a), .code_b(code_b), .code_c(code_c), .code_d(code_d),
      .serial_data_out(sdo1), .load_enable_out(le1), .busy(busy1), .done(done1),
      .frames_sent(fs1), .send_state(st1)
   );

   always #5 clk = ~clk;

   int nc = 0;
   int nf = 0;
   bit chk_en = 1'b0;

   // Model: mk = enabled cycles since the frame was accepted (0 = idle, 34+gap = done cycle).
   int          mk [2];
   logic [31:0] mfr[2];
   int          mfc[2];
   int          mg [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nc++;
      if (act !== exp) begin
         nf++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      mk[0] = 0; mk[1] = 0; mfc[0] = 0; mfc[1] = 0; mfr[0] = 0; mfr[1] = 0;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
               mk[i] = 0; mfr[i] = 32'd0; mfc[i] = 0;
            end
         end else if (enable) begin
            for (int i = 0; i < 2; i++) begin
               if (mk[i] == 0 || mk[i] == 34 + mg[i]) begin
                  if (start) begin
                     mk[i]  = 1;
                     mfr[i] = {code_a, code_b, code_c, code_d};
                  end else begin
                     mk[i] = 0;
                  end
               end else begin
                  mk[i]++;
                  if (mk[i] == 34 + mg[i]) mfc[i] = (mfc[i] + 1) % 256;
               end
            end
         end
      end
   end

   task automatic compare_inst(input int i);
      int         k, p;
      logic       e_le, e_busy, e_sdo, e_done;
      logic [1:0] e_st;
      k = mk[i];
      p = 34 + mg[i];
      e_le   = (k >= 1 && k <= 33);
      e_busy = (k >= 1 && k <= 33 + mg[i]);
      e_sdo  = (k >= 2 && k <= 33) ? mfr[i][33-k] : 1'b0;
      e_done = (k == p);
      e_st   = (k == 0 || k == p) ? 2'd0 : (k == 1) ? 2'd1 : (k <= 33) ? 2'd2 : 2'd3;
      chk($sformatf("u%0d_sdo", i),   (i == 0) ? sdo0  : sdo1,  e_sdo);
      chk($sformatf("u%0d_le", i),    (i == 0) ? le0   : le1,   e_le);
      chk($sformatf("u%0d_busy", i),  (i == 0) ? busy0 : busy1, e_busy);
      chk($sformatf("u%0d_done", i),  (i == 0) ? done0 : done1, e_done);
      chk($sformatf("u%0d_frames", i),(i == 0) ? fs0   : fs1,   mfc[i]);
      chk($sformatf("u%0d_state", i), (i == 0) ? st0   : st1,   e_st);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            compare_inst(0);
            compare_inst(1);
         end
      end
   end

   initial begin
      logic [31:0] bits;
      int le_cnt, dn, dcyc, cnt, c1, c2, d0a, d0b, n0;
      logic [7:0] wrap_fs;
      mg[0] = 2;
      mg[1] = 1;

      // Reset
      #1 reset_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) step();
      reset_n = 1'b1;
      enable  = 1'b1;
      step();
      step();
      chk("rst_frames", fs0, 8'd0);
      chk("rst_le", le0, 1'b0);
      chk("rst_busy", busy0, 1'b0);

      // Basic frame
      code_a = 8'hA5; code_b = 8'h3C; code_c = 8'hFF; code_d = 8'h00;
      start = 1'b1;
      step();
      start = 1'b0;
      bits = 32'd0; le_cnt = 0; dn = 0; dcyc = -1;
      for (int n = 1; n <= 40; n++) begin
         if (le0) le_cnt++;
         if (n >= 2 && n <= 33) bits = {bits[30:0], sdo0};
         if (done0) begin dn++; dcyc = n; chk("basic_frames_at_done", fs0, 8'd1); end
         if (n < 40) step();
      end
      chk("basic_bits", bits, 32'hA53CFF00);
      chk("basic_le_len", le_cnt, 33);
      chk("basic_done_cnt", dn, 1);
      chk("basic_done_cycle", dcyc, 36);

      // Start while busy
      code_a = 8'h12; code_b = 8'h34; code_c = 8'h56; code_d = 8'h78;
      start = 1'b1;
      step();
      start = 1'b0;
      bits = 32'd0; dn = 0; dcyc = -1;
      for (int n = 1; n <= 45; n++) begin
         if (n >= 2 && n <= 33) bits = {bits[30:0], sdo0};
         if (done0) begin dn++; dcyc = n; end
         if (n == 45) chk("busy_no_restart", busy0, 1'b0);
         start = (n == 10 || n == 20);
         if (start) begin
            code_a = 8'($urandom); code_b = 8'($urandom);
            code_c = 8'($urandom); code_d = 8'($urandom);
         end
         if (n < 45) step();
      end
      start = 1'b0;
      chk("busy_bits", bits, 32'h12345678);
      chk("busy_done_cnt", dn, 1);
      chk("busy_done_cycle", dcyc, 36);

      // Enable stall at bit 12
      code_a = 8'hA5; code_b = 8'h3C; code_c = 8'hFF; code_d = 8'h00;
      start = 1'b1;
      step();
      start = 1'b0;
      bits = 32'd0; dcyc = -1;
      for (int n = 1; n <= 45; n++) begin
         if ((n >= 2 && n <= 14) || (n >= 20 && n <= 38)) bits = {bits[30:0], sdo0};
         if (n == 17) begin
            chk("stall_sdo", sdo0, 1'b1);
            chk("stall_le", le0, 1'b1);
            chk("stall_state", st0, 2'd2);
         end
         if (done0) dcyc = n;
         enable = !(n >= 14 && n <= 18);
         if (n < 45) step();
      end
      enable = 1'b1;
      chk("stall_bits", bits, 32'hA53CFF00);
      chk("stall_done_cycle", dcyc, 41);

      // Async reset mid-frame
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (19) step();
      chk("pre_rst_le", le0, 1'b1);
      chk("pre_rst_frames", fs0, 8'd3);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_le", le0, 1'b0);
      chk("arst_sdo", sdo0, 1'b0);
      chk("arst_busy", busy0, 1'b0);
      chk("arst_frames", fs0, 8'd0);
      step();
      reset_n = 1'b1;
      dn = 0;
      repeat (40) begin
         step();
         if (done0) dn++;
      end
      chk("arst_no_done", dn, 0);
      chk("arst_frames_after", fs0, 8'd0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         start  = ($urandom_range(0, 19) == 0);
         enable = ($urandom_range(0, 9) != 0);
         code_a = 8'($urandom); code_b = 8'($urandom);
         code_c = 8'($urandom); code_d = 8'($urandom);
         step();
      end
      start = 1'b0;
      enable = 1'b1;
      repeat (40) step();

      // Back-to-back frames, counter wrap on the zero-gap instance
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      start = 1'b1;
      cnt = 0; c1 = 0; c2 = 0; n0 = 0; d0a = 0; d0b = 0; wrap_fs = 8'hAA;
      for (int c = 0; c < 256 * 35 + 200 && cnt < 256; c++) begin
         code_a = 8'($urandom); code_b = 8'($urandom);
         step();
         if (done1) begin
            cnt++;
            if (cnt == 1) c1 = c;
            if (cnt == 2) c2 = c;
            if (cnt == 256) wrap_fs = fs1;
         end
         if (done0) begin
            n0++;
            if (n0 == 1) d0a = c;
            if (n0 == 2) d0b = c;
         end
      end
      start = 1'b0;
      chk("wrap_done_cnt", cnt, 256);
      chk("wrap_frames", wrap_fs, 8'd0);
      chk("min_gap_period", c2 - c1, 35);
      chk("default_period", d0b - d0a, 36);
      repeat (40) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
      $finish;
   end

endmodule

// File: doc/iz_param_sender.md
# iz_param_sender

Serial parameter transmitter for the Izhikevich neuron parameter path. It accepts four 8-bit raw parameter codes (a, b, c, d), frames them, and drives the 1-bit serial link and its load_enable framing strobe into the neuron-side parameter loader. It sits on the controller/test side of the link, and its outputs wire directly to the loader's serial_data_in and load_enable.

## Interface
Parameters:
- GAP_CYCLES, 2, number of cycles load_enable_out is held low after a frame; legal range 1–15; 0 is treated as 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  global clock enable, shared with the loader; when low, all state and outputs hold.
- start  in  1  request to send one frame; sampled only in IDLE with enable=1.
- code_a  in  8  raw code for parameter a.
- code_b  in  8  raw code for parameter b.
- code_c  in  8  raw code for parameter c.
- code_d  in  8  raw code for parameter d.
- serial_data_out  out  1  serial bit to loader, MSB-first.
- load_enable_out  out  1  frame strobe to loader.
- busy  out  1  high from SYNC through the last GAP cycle.
- done  out  1  one-cycle pulse when a frame completes.
- frames_sent  out  8  count of completed frames; wraps 255→0.
- send_state  out  2  debug copy of the FSM state.

## Operation
- FSM states: IDLE=0, SYNC=1, SHIFT=2, GAP=3. All outputs are registered.
- IDLE: load_enable_out=0, serial_data_out=0, busy=0. When start=1 and enable=1:
  - latch frame_reg = {code_a, code_b, code_c, code_d} (32 bits; a goes first),
  - clear bit_cnt,
  - go to SYNC.
- SYNC: one cycle, load_enable_out=1, serial_data_out=0. This produces the rising edge that the loader detects; the loader ignores data in this cycle. Next state is SHIFT.
- SHIFT: 32 cycles with load_enable_out=1. Each cycle drives serial_data_out=frame_reg[31] and then shifts frame_reg left by 1. bit_cnt is a 5-bit counter, 0..31. At bit_cnt=31, go to GAP and load gap_cnt=GAP_CYCLES.
- GAP: load_enable_out=0, serial_data_out=0 for GAP_CYCLES cycles. This returns the loader from READY to IDLE. On the final GAP cycle:
  - next state is IDLE,
  - done pulses in the following cycle,
  - frames_sent increments, wrapping modulo 256.
- start asserted outside IDLE is ignored, with no queuing. Changes to code_x inputs after the latch do not affect the frame in flight.
- enable=0 in any state: FSM, counters, frame_reg and all outputs hold their values. A held done stays high until enable returns. The loader sees a frozen link.
- Reset (reset_n=0, asynchronous) forces:
  - state=IDLE, frame_reg=0, bit_cnt=0, gap_cnt=0,
  - serial_data_out=0, load_enable_out=0, busy=0, done=0, frames_sent=0.
- Reset mid-frame aborts the frame immediately. The loader sees load_enable fall, and no done is issued.

## Timing
- Let T be the cycle in which start is sampled high in IDLE with enable=1.
- T+1: SYNC. load_enable_out=1, busy=1.
- T+2 … T+33: data bits a[7] … d[0], one bit per cycle.
- T+34 … T+33+GAP_CYCLES: load_enable_out=0, busy=1.
- T+34+GAP_CYCLES: IDLE, done=1 for one cycle, frames_sent updated, busy=0.
- Frame period is 34+GAP_CYCLES cycles (36 by default). A new start is accepted in the same cycle done is high, giving back-to-back frames 36 cycles apart.
- Each enable-low cycle extends all of the above by one cycle.

## Test plan
- Basic frame: reset, then codes a=0xA5, b=0x3C, c=0xFF, d=0x00, start one cycle.
  - load_enable_out high for exactly 33 cycles (T+1..T+33).
  - Serial bits at T+2.. read 1010_0101 0011_1100 1111_1111 0000_0000.
  - done at T+36, frames_sent=1.
- Loopback: connect to the loader, send a=0x40, c=0x80, d=0x20.
  - Loader params_ready rises.
  - Loader returns to IDLE within GAP_CYCLES.
  - frames_sent=1.
- Start while busy: pulse start at T+10 and T+20.
  - Frame is unchanged.
  - Exactly one done.
  - Next frame starts only on a start after IDLE.
- Enable stall: drop enable for 5 cycles during SHIFT at bit 12.
  - Outputs frozen for those 5 cycles.
  - Bit sequence intact.
  - done at T+41.
- Async reset mid-frame: assert reset_n=0 at T+20 between clock edges.
  - load_enable_out, serial_data_out and busy go 0 immediately, without waiting for a clock edge.
  - No done.
  - frames_sent=0.
- Counter wrap and min gap: GAP_CYCLES=0 gives a 1-cycle gap and a 35-cycle period. After 256 back-to-back frames, frames_sent=0.
